// File: rtl/move_load.sv
// move_load: filters evaluated child positions that leave the mover in check,
// streams the survivors into the move_sort RAM, kicks off the sort and reports
// the ply outcome (legal-move count, overflow, mate, stalemate).
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | after reset, waiting for load_start
// S_INIT       | one cycle: rewind the sort RAM write pointer, clear the sort
// S_LOAD       | accepting child entries, writing the legal ones
// S_SORT_START | final write lands this cycle; sort_start is issued next cycle
// S_SORT_WAIT  | waiting for move_sort; first cycle ignores stale completion
// S_DONE       | ply complete, results held, waiting for next load_start

`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif

module move_load #(
  parameter int RAM_WIDTH          = 32,
  parameter int EVAL_WIDTH         = 16,
  parameter int MAX_POSITIONS      = `MAX_POSITIONS,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic                          white_to_move,
  input  logic                          side_in_check,
  input  logic                          in_valid,
  input  logic [RAM_WIDTH-1:0]          in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          ram_wr_addr_init,
  output logic                          ram_wr,
  output logic [RAM_WIDTH-1:0]          ram_wr_data,
  output logic                          sort_clear,
  output logic                          sort_start,
  input  logic                          sort_complete,
  output logic [MAX_POSITIONS_LOG2:0]   legal_count,
  output logic                          overflow,
  output logic                          mate,
  output logic                          stalemate,
  output logic                          load_done
);

  localparam int CW = MAX_POSITIONS_LOG2 + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_POSITIONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_SORT_START,
    S_SORT_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  wtm_q, wtm_d;
  logic                  sic_q, sic_d;
  logic [CW-1:0]         legal_count_q, legal_count_d;
  logic                  overflow_q, overflow_d;
  logic                  mate_q, mate_d;
  logic                  stalemate_q, stalemate_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [RAM_WIDTH-1:0]  ram_wr_data_q, ram_wr_data_d;
  logic                  sort_start_q, sort_start_d;

  logic                  accept;
  logic                  illegal;
  logic                  room;

  // Next-state and next-output logic; writes are registered so an entry
  // accepted in one cycle appears on the RAM port in the next.
  always_comb begin
    state_d       = state_q;
    wtm_d         = wtm_q;
    sic_d         = sic_q;
    legal_count_d = legal_count_q;
    overflow_d    = overflow_q;
    mate_d        = mate_q;
    stalemate_d   = stalemate_q;
    ram_wr_d      = 1'b0;
    ram_wr_data_d = ram_wr_data_q;
    sort_start_d  = 1'b0;

    accept  = (state_q == S_LOAD) && in_valid;
    // Both check bits set is resolved purely by the mover's bit.
    illegal = wtm_q ? in_data[EVAL_WIDTH+1] : in_data[EVAL_WIDTH];
    room    = (legal_count_q < MAX_CNT);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_d       = S_INIT;
          wtm_d         = white_to_move;
          sic_d         = side_in_check;
          legal_count_d = '0;
          overflow_d    = 1'b0;
          mate_d        = 1'b0;
          stalemate_d   = 1'b0;
        end
      end

      S_INIT: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (accept) begin
          if (!illegal) begin
            if (room) begin
              ram_wr_d      = 1'b1;
              ram_wr_data_d = in_data;
              legal_count_d = legal_count_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (in_last) begin
            if (legal_count_d != '0) begin
              state_d = S_SORT_START;
            end else begin
              state_d     = S_DONE;
              mate_d      = sic_q;
              stalemate_d = ~sic_q;
            end
          end
        end
      end

      // sort_start is registered, so it rises the cycle after the last write.
      S_SORT_START: begin
        sort_start_d = 1'b1;
        state_d      = S_SORT_WAIT;
      end

      // While sort_start is still high, sort_complete is from the previous sort.
      S_SORT_WAIT: begin
        if (!sort_start_q && sort_complete) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any ply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wtm_q         <= 1'b0;
      sic_q         <= 1'b0;
      legal_count_q <= '0;
      overflow_q    <= 1'b0;
      mate_q        <= 1'b0;
      stalemate_q   <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_wr_data_q <= '0;
      sort_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wtm_q         <= wtm_d;
      sic_q         <= sic_d;
      legal_count_q <= legal_count_d;
      overflow_q    <= overflow_d;
      mate_q        <= mate_d;
      stalemate_q   <= stalemate_d;
      ram_wr_q      <= ram_wr_d;
      ram_wr_data_q <= ram_wr_data_d;
      sort_start_q  <= sort_start_d;
    end
  end

  assign in_ready         = (state_q == S_LOAD);
  assign ram_wr_addr_init = (state_q == S_INIT);
  assign sort_clear       = (state_q == S_INIT);
  assign load_done        = (state_q == S_DONE);
  assign ram_wr           = ram_wr_q;
  assign ram_wr_data      = ram_wr_data_q;
  assign sort_start       = sort_start_q;
  assign legal_count      = legal_count_q;
  assign overflow         = overflow_q;
  assign mate             = mate_q;
  assign stalemate        = stalemate_q;

endmodule
